// File: rtl/tl_probe_pkg.sv
// Shared TileLink B/C probe definitions: opcodes, cap/report/perm encodings and
// the report decode helpers used by the probe engine.
package tl_probe_pkg;

    localparam logic [2:0] OP_PROBE        = 3'd6;
    localparam logic [2:0] OP_PROBEACK     = 3'd4;
    localparam logic [2:0] OP_PROBEACKDATA = 3'd5;

    typedef enum logic [1:0] {
        CAP_TOT = 2'd0,
        CAP_TOB = 2'd1,
        CAP_TON = 2'd2
    } cap_e;

    typedef enum logic [2:0] {
        RPT_TTOB = 3'd0,
        RPT_TTON = 3'd1,
        RPT_BTON = 3'd2,
        RPT_TTOT = 3'd3,
        RPT_BTOB = 3'd4,
        RPT_NTON = 3'd5
    } report_e;

    typedef enum logic [1:0] {
        PERM_NOTHING = 2'd0,
        PERM_BRANCH  = 2'd1,
        PERM_TRUNK   = 2'd2
    } perm_e;

    function automatic logic [1:0] report_to_perm(input logic [2:0] rpt);
        logic [1:0] perm;
        case (rpt)
            RPT_TTOB, RPT_BTOB: perm = PERM_BRANCH;
            RPT_TTOT:           perm = PERM_TRUNK;
            default:            perm = PERM_NOTHING;
        endcase
        return perm;
    endfunction

    // A report may never leave the client holding more than the cap allows.
    function automatic logic report_legal(input logic [1:0] cap, input logic [2:0] rpt);
        logic ok;
        case (cap)
            CAP_TON: ok = (rpt == RPT_TTON) || (rpt == RPT_BTON) || (rpt == RPT_NTON);
            CAP_TOB: ok = (rpt != RPT_TTOT);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tl_probe_issuer.sv
// Manager-side probe engine: one Probe on B, collect ProbeAck/ProbeAckData on C,
// forward dirty beats to the writeback buffer, then report perm/dirty/err.
module tl_probe_issuer
    import tl_probe_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int SOURCE_W = 4,
    parameter int DATA_W   = 64,
    parameter int BEATS    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [SOURCE_W-1:0] req_source,
    input  logic [1:0]          req_cap,
    output logic                b_valid,
    input  logic                b_ready,
    output logic [2:0]          b_opcode,
    output logic [1:0]          b_param,
    output logic [ADDR_W-1:0]   b_address,
    output logic [SOURCE_W-1:0] b_source,
    input  logic                c_valid,
    output logic                c_ready,
    input  logic [2:0]          c_opcode,
    input  logic [2:0]          c_param,
    input  logic [ADDR_W-1:0]   c_address,
    input  logic [DATA_W-1:0]   c_data,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [DATA_W-1:0]   wb_data,
    output logic                wb_last,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [1:0]          resp_perm,
    output logic                resp_dirty,
    output logic                resp_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PROBE = 3'd1,
        S_ACK   = 3'd2,
        S_DATA  = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    localparam int              CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [SOURCE_W-1:0]   source_q, source_d;
    logic [1:0]            cap_q, cap_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            perm_q, perm_d;
    logic                  dirty_q, dirty_d;
    logic                  err_q, err_d;

    logic c_is_ack;
    logic c_is_data;
    logic c_fire;

    always_comb begin
        c_is_ack  = (c_opcode == OP_PROBEACK);
        c_is_data = (c_opcode == OP_PROBEACKDATA);

        // Data beats only move when the writeback buffer can take them, so C and
        // WB handshakes stay locked together; unknown opcodes are never accepted.
        c_ready = 1'b0;
        case (state_q)
            S_ACK:   c_ready = c_is_data ? wb_ready : c_is_ack;
            S_DATA:  c_ready = c_is_data && wb_ready;
            default: c_ready = 1'b0;
        endcase
        c_fire = c_valid && c_ready;

        req_ready  = (state_q == S_IDLE);
        b_valid    = (state_q == S_PROBE);
        b_opcode   = OP_PROBE;
        b_param    = cap_q;
        b_address  = addr_q;
        b_source   = source_q;
        wb_valid   = c_valid && c_is_data && ((state_q == S_ACK) || (state_q == S_DATA));
        wb_data    = c_data;
        wb_last    = (BEATS == 1) || (cnt_q == CNT_LAST);
        resp_valid = (state_q == S_RESP);
        resp_perm  = perm_q;
        resp_dirty = dirty_q;
        resp_err   = err_q;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        source_d = source_q;
        cap_d    = cap_q;
        cnt_d    = cnt_q;
        perm_d   = perm_q;
        dirty_d  = dirty_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    source_d = req_source;
                    cap_d    = req_cap;
                    state_d  = S_PROBE;
                end
            end
            S_PROBE: begin
                if (b_ready) state_d = S_ACK;
            end
            S_ACK: begin
                if (c_fire) begin
                    dirty_d = c_is_data;
                    perm_d  = report_to_perm(c_param);
                    err_d   = (c_address != addr_q) || !report_legal(cap_q, c_param);
                    if (c_is_ack || (BEATS == 1)) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (c_fire) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    perm_d  = '0;
                    dirty_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            source_q <= '0;
            cap_q    <= '0;
            cnt_q    <= '0;
            perm_q   <= '0;
            dirty_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            source_q <= source_d;
            cap_q    <= cap_d;
            cnt_q    <= cnt_d;
            perm_q   <= perm_d;
            dirty_q  <= dirty_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_tl_probe_issuer.sv
// Directed bench for tl_probe_issuer: probe handshakes, ack/data streams, error
// reporting, stalls and mid-transfer reset, all against hand-computed values.
module tb_tl_probe_issuer;

    localparam int ADDR_W   = 32;
    localparam int SOURCE_W = 4;
    localparam int DATA_W   = 64;
    localparam int BEATS    = 8;

    logic                clock = 1'b0;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_addr;
    logic [SOURCE_W-1:0] req_source;
    logic [1:0]          req_cap;
    logic                b_valid;
    logic                b_ready;
    logic [2:0]          b_opcode;
    logic [1:0]          b_param;
    logic [ADDR_W-1:0]   b_address;
    logic [SOURCE_W-1:0] b_source;
    logic                c_valid;
    logic                c_ready;
    logic [2:0]          c_opcode;
    logic [2:0]          c_param;
    logic [ADDR_W-1:0]   c_address;
    logic [DATA_W-1:0]   c_data;
    logic                wb_valid;
    logic                wb_ready;
    logic [DATA_W-1:0]   wb_data;
    logic                wb_last;
    logic                resp_valid;
    logic                resp_ready;
    logic [1:0]          resp_perm;
    logic                resp_dirty;
    logic                resp_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    tl_probe_issuer #(
        .ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W), .DATA_W(DATA_W), .BEATS(BEATS)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_source(req_source), .req_cap(req_cap),
        .b_valid(b_valid), .b_ready(b_ready), .b_opcode(b_opcode), .b_param(b_param),
        .b_address(b_address), .b_source(b_source),
        .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_param(c_param),
        .c_address(c_address), .c_data(c_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_last(wb_last),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_perm(resp_perm),
        .resp_dirty(resp_dirty), .resp_err(resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Request a probe, check the B channel one cycle later, optionally stall b_ready.
    task automatic probe(input logic [31:0] adr, input logic [3:0] src,
                         input logic [1:0] cap, input int hold);
        req_valid  = 1'b1;
        req_addr   = adr;
        req_source = src;
        req_cap    = cap;
        #1;
        chk("req_ready_idle", req_ready, 1);
        chk("b_valid_idle", b_valid, 0);
        tick();
        req_valid  = 1'b0;
        req_addr   = ~adr;
        req_source = ~src;
        req_cap    = 2'd3;
        #1;
        chk("b_valid", b_valid, 1);
        chk("b_opcode", b_opcode, 6);
        chk("b_param", b_param, cap);
        chk("b_address", b_address, adr);
        chk("b_source", b_source, src);
        chk("req_ready_busy", req_ready, 0);
        chk("c_ready_probe", c_ready, 0);
        for (int i = 0; i < hold; i++) begin
            b_ready = 1'b0;
            tick();
            chk("b_valid_hold", b_valid, 1);
            chk("b_address_hold", b_address, adr);
        end
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        #1;
        chk("b_valid_after", b_valid, 0);
    endtask

    // ProbeAckData stream; beat i carries base+i.
    task automatic stream(input logic [2:0] prm, input logic [31:0] adr, input bit toggle,
                          input logic [63:0] base, input int nbeats);
        int beat = 0;
        int cyc  = 0;
        c_valid   = 1'b1;
        c_opcode  = 3'd5;
        c_param   = prm;
        c_address = adr;
        while (beat < nbeats && cyc < 64) begin
            wb_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            c_data   = base + 64'(beat);
            #1;
            chk("wb_valid", wb_valid, 1);
            chk("wb_data", wb_data, base + 64'(beat));
            chk("c_ready_data", c_ready, wb_ready);
            if (wb_ready) chk("wb_last", wb_last, (beat == BEATS - 1));
            tick();
            if (wb_ready) beat++;
            cyc++;
        end
        chk("beat_count", beat, nbeats);
        c_valid  = 1'b0;
        wb_ready = 1'b0;
    endtask

    task automatic single_ack(input logic [2:0] prm, input logic [31:0] adr);
        c_valid   = 1'b1;
        c_opcode  = 3'd4;
        c_param   = prm;
        c_address = adr;
        #1;
        chk("c_ready_ack", c_ready, 1);
        chk("wb_valid_ack", wb_valid, 0);
        tick();
        c_valid = 1'b0;
        #1;
        chk("resp_latency", resp_valid, 1);
    endtask

    task automatic finish_resp(input logic [1:0] perm, input logic dirty, input logic err);
        int n = 0;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("resp_valid", resp_valid, 1);
        chk("resp_perm", resp_perm, perm);
        chk("resp_dirty", resp_dirty, dirty);
        chk("resp_err", resp_err, err);
        chk("req_ready_resp", req_ready, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        chk("resp_valid_done", resp_valid, 0);
        chk("req_ready_done", req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 0; req_addr = '0; req_source = '0; req_cap = '0;
        b_ready = 0; c_valid = 0; c_opcode = '0; c_param = '0; c_address = '0;
        c_data = '0; wb_ready = 0; resp_ready = 0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_b_address", b_address, 0);
        chk("rst_b_param", b_param, 0);
        chk("rst_b_source", b_source, 0);
        chk("rst_resp_perm", resp_perm, 0);
        chk("rst_resp_dirty", resp_dirty, 0);
        chk("rst_resp_err", resp_err, 0);

        // 1: toN, ProbeAck NtoN
        probe(32'h8000_0040, 4'd3, 2'd2, 0);
        single_ack(3'd5, 32'h8000_0040);
        finish_resp(2'd0, 1'b0, 1'b0);

        // 2: toB, ProbeAckData TtoB with writeback backpressure every other cycle
        probe(32'h8000_0040, 4'd5, 2'd1, 0);
        stream(3'd0, 32'h8000_0040, 1'b1, 64'd0, BEATS);
        finish_resp(2'd1, 1'b1, 1'b0);

        // 3: toT, b_ready held low for 5 cycles, ProbeAck TtoT
        probe(32'h8000_1000, 4'd7, 2'd0, 5);
        single_ack(3'd3, 32'h8000_1000);
        finish_resp(2'd2, 1'b0, 1'b0);

        // 4: address mismatch still consumes all beats and flags err
        probe(32'h8000_0040, 4'd1, 2'd2, 0);
        stream(3'd1, 32'h8000_0080, 1'b0, 64'hA000, BEATS);
        finish_resp(2'd0, 1'b1, 1'b1);

        // 5: reset after beat 3 of a data stream, then a clean transaction
        probe(32'h8000_0040, 4'd2, 2'd1, 0);
        stream(3'd0, 32'h8000_0040, 1'b0, 64'hB000, 4);
        c_valid  = 1'b1;
        c_opcode = 3'd5;
        wb_ready = 1'b1;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_wb_valid", wb_valid, 0);
        chk("midrst_c_ready", c_ready, 0);
        chk("midrst_b_address", b_address, 0);
        c_valid  = 1'b0;
        wb_ready = 1'b0;
        probe(32'h8000_2040, 4'd4, 2'd1, 0);
        stream(3'd4, 32'h8000_2040, 1'b0, 64'hC000, BEATS);
        finish_resp(2'd1, 1'b1, 1'b0);

        // 6: illegal opcode stalls in S_ACK; legal ProbeAck next cycle is taken
        probe(32'h8000_0100, 4'd6, 2'd0, 0);
        c_valid   = 1'b1;
        c_opcode  = 3'd0;
        c_param   = 3'd3;
        c_address = 32'h8000_0100;
        wb_ready  = 1'b1;
        #1;
        chk("badop_c_ready", c_ready, 0);
        chk("badop_wb_valid", wb_valid, 0);
        tick();
        chk("badop_no_resp", resp_valid, 0);
        wb_ready = 1'b0;
        single_ack(3'd3, 32'h8000_0100);
        finish_resp(2'd2, 1'b0, 1'b0);

        // 7: toB cap with a TtoT report is illegal
        probe(32'h8000_0140, 4'd0, 2'd1, 0);
        single_ack(3'd3, 32'h8000_0140);
        finish_resp(2'd2, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
